// File: rtl/daq_pkg.sv
// daq_pkg: DAQ word constants, checker states, error bit indices and the CRC-22 step shared by the
// readout producer and the receive checker.
package daq_pkg;
  localparam logic [18:0] DAQ_IDLE = 19'h40000;
  localparam logic [18:0] DAQ_HDR = 19'h0DB0A;
  localparam logic [18:0] DAQ_EOF = 19'h0DE0D;
  localparam logic [18:0] DAQ_PAD = 19'h03000;
  localparam logic [7:0] DAQ_TRL_TAG = 8'h3A;
  localparam int ERR_HDR = 0;
  localparam int ERR_LEN = 1;
  localparam int ERR_CRC = 2;
  localparam int ERR_ABT = 3;
  localparam int ERR_TO = 4;
  typedef enum logic [2:0] {IDLE, HDR, BODY, CRC0, CRC1, TRL, DONE, DRAIN} daq_state_t;
  // x^22+x+1, MSB of the 16-bit slice first
  function automatic logic [21:0] crc22_step(input logic [21:0] c, input logic [15:0] d);
    logic [21:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = {r[20:0], 1'b0} ^ ((r[21] ^ d[i]) ? 22'h3 : 22'h0);
    return r;
  endfunction
endpackage

// File: rtl/daq_rx_checker_if.sv
// daq_rx_checker_if: DAQ word stream into the checker, frame status and header fields out of it.
interface daq_rx_checker_if;
  logic [18:0] daqp;
  logic frame_done;
  logic frame_ok;
  logic [4:0] err;
  logic [11:0] bxn_l1a;
  logic [11:0] l1a_cnt;
  logic [11:0] rdout_cnt;
  logic [3:0] lct_bins;
  logic [4:0] raw_bins;
  logic [15:0] good_frames;
  logic [15:0] bad_frames;
  modport master(output daqp, input frame_done, frame_ok, err, bxn_l1a, l1a_cnt, rdout_cnt, lct_bins,
                 raw_bins, good_frames, bad_frames);
  modport slave(input daqp, output frame_done, frame_ok, err, bxn_l1a, l1a_cnt, rdout_cnt, lct_bins,
                raw_bins, good_frames, bad_frames);
endinterface

// File: rtl/crc22_chk.sv
// crc22_chk: registered CRC-22 over 16-bit slices; clear together with enable restarts on the new slice.
module crc22_chk
  import daq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic [15:0] i_d,
  output logic [21:0] o_crc
);
  always_ff @(posedge clk)
    if (rst) o_crc <= '0;
    else if (i_en) o_crc <= crc22_step(i_clr ? 22'd0 : o_crc, i_d);
    else if (i_clr) o_crc <= '0;
endmodule

// File: rtl/daq_rx_checker.sv
// daq_rx_checker: parses ALCT DAQ frames, captures header fields, checks framing/length/CRC-22.
module daq_rx_checker
  import daq_pkg::*;
#(
  parameter int MAX_WORDS = 2047,
  parameter int TIMEOUT = 4095
) (
  input logic clk,
  input logic hard_rst,
  daq_rx_checker_if.slave bus
);
  daq_state_t r_st, w_st, w_nxt;
  logic [18:0] r_d;
  logic [10:0] r_wc, w_wc, w_inc, r_lo;
  logic [4:0] r_err, w_err, w_base;
  logic r_hold, w_hold, w_clr, w_en, w_to, w_cap, w_bad, w_len_bad;
  logic [21:0] w_crc;
  crc22_chk u_crc (.clk(clk), .rst(hard_rst), .i_clr(w_clr), .i_en(w_en), .i_d(r_d[15:0]), .o_crc(w_crc));
`ifdef DAQ_RX_TIMEOUT_EN
  logic [11:0] r_tc;
  always_ff @(posedge clk) r_tc <= (hard_rst || w_clr) ? 12'd1 : (&r_tc ? r_tc : r_tc + 12'd1);
  assign w_to = r_st inside {HDR, BODY, CRC0, CRC1, TRL} && int'(r_tc) >= TIMEOUT;
`else
  assign w_to = 1'b0;
`endif
  assign w_inc = &r_wc ? r_wc : r_wc + 11'd1;
  assign w_bad = r_wc < 11'd4 ? r_d[18:12] != 7'h0D : r_wc < 11'd7 ? r_d[18:15] != 4'd0 : r_d[14:9] != 6'h05;
  assign w_len_bad = r_d[18:11] != DAQ_TRL_TAG || r_d[10:0] != w_inc || w_inc[1:0] != 2'd0 ||
                     int'(w_inc) > MAX_WORDS;
  assign w_cap = w_st == HDR && !w_to && !r_d[18];
  always_comb begin
    w_st = r_st == DONE ? (r_hold ? HDR : (r_err[ERR_TO] ? DRAIN : IDLE)) : r_st;
    w_base = r_st == DONE ? 5'd0 : r_err;
    w_nxt = w_st;
    w_wc = w_inc;
    w_err = w_base;
    w_hold = 1'b0;
    w_clr = 1'b0;
    w_en = 1'b0;
    if (w_to) begin
      w_err[ERR_TO] = 1'b1;
      w_nxt = DONE;
    end else if (w_st == DRAIN) begin
      w_nxt = r_d[18] ? IDLE : DRAIN;
    end else if (w_st == IDLE) begin
      if (r_d == DAQ_HDR) begin
        w_nxt = HDR;
        w_wc = 11'd1;
        w_clr = 1'b1;
        w_en = 1'b1;
        w_err = '0;
      end else if (!r_d[18]) begin
        w_err[ERR_HDR] = 1'b1;
        w_nxt = DONE;
      end
    end else if (r_d[18] || (w_st == BODY && r_d == DAQ_HDR)) begin
      w_err[ERR_ABT] = 1'b1;
      w_nxt = DONE;
      w_wc = 11'd1;
      w_hold = !r_d[18];
      w_clr = !r_d[18];
      w_en = !r_d[18];
    end else begin
      w_en = w_st == HDR || w_st == BODY;
      w_err[ERR_HDR] = w_base[ERR_HDR] | (w_st == HDR && w_bad);
      w_err[ERR_CRC] = w_base[ERR_CRC] | (w_st == CRC1 && {r_d[10:0], r_lo} != w_crc);
      w_err[ERR_LEN] = w_base[ERR_LEN] | (w_st == TRL && w_len_bad);
      w_nxt = w_st == HDR ? (r_wc == 11'd7 ? BODY : HDR) : w_st == BODY ? (r_d == DAQ_EOF ? CRC0 : BODY) :
              w_st == CRC0 ? CRC1 : w_st == CRC1 ? TRL : DONE;
    end
  end
  always_ff @(posedge clk)
    if (hard_rst) begin
      r_st <= IDLE;
      r_d <= DAQ_IDLE;
      r_wc <= '0;
      r_err <= '0;
      r_lo <= '0;
      r_hold <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_ok <= 1'b0;
      bus.err <= '0;
      bus.bxn_l1a <= '0;
      bus.l1a_cnt <= '0;
      bus.rdout_cnt <= '0;
      bus.lct_bins <= '0;
      bus.raw_bins <= '0;
      bus.good_frames <= '0;
      bus.bad_frames <= '0;
    end else begin
      r_d <= bus.daqp;
      r_st <= w_nxt;
      r_wc <= w_wc;
      r_err <= w_err;
      r_hold <= w_hold;
      if (r_st == CRC0) r_lo <= r_d[10:0];
      if (w_cap && r_wc == 11'd1) bus.bxn_l1a <= r_d[11:0];
      if (w_cap && r_wc == 11'd2) bus.l1a_cnt <= r_d[11:0];
      if (w_cap && r_wc == 11'd3) bus.rdout_cnt <= r_d[11:0];
      if (w_cap && r_wc == 11'd7) bus.lct_bins <= r_d[8:5];
      if (w_cap && r_wc == 11'd7) bus.raw_bins <= r_d[4:0];
      bus.frame_done <= r_st == DONE;
      if (r_st == DONE) begin
        bus.err <= r_err;
        bus.frame_ok <= r_err == 5'd0;
        bus.good_frames <= bus.good_frames + 16'(r_err == 5'd0 && !(&bus.good_frames));
        bus.bad_frames <= bus.bad_frames + 16'(r_err != 5'd0 && !(&bus.bad_frames));
      end
    end
endmodule

// File: doc/daq_rx_checker.md
Name: daq_rx_checker

Overview:
- Receiving end of the ALCT 19-bit DAQ readout stream.
- Parses each frame from header to trailer and extracts the header fields: L1A BXN, L1A count, readout count, LCT bins and raw bins.
- Checks framing, word count, padding and CRC-22, and flags errors.
- Sits on the readout side, for loopback self-test and for monitoring data that the readout path emits.

Parameters:
- MAX_WORDS, 2047: largest legal frame length in words. The trailer length field is 11 bits wide.
- TIMEOUT, 4095: maximum number of cycles from header to trailer before the frame is aborted. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- hard_rst  in  1  synchronous reset, active-high.
- daqp  in  19  DAQ word stream, one word per cycle.
  - Bit 18 = 1 marks an idle/filler word, e.g. 19'h40000.
  - Bit 18 = 0 marks a frame word.
- frame_done  out  1  one-cycle pulse when a frame ends, whether good or bad.
- frame_ok  out  1  valid with frame_done; 1 means no error bits are set.
- err  out  5  sticky error bits for the current frame, valid with frame_done:
  - [0] hdr_err
  - [1] len_err
  - [2] crc_err
  - [3] abort (idle word, or a new header, seen mid-frame)
  - [4] timeout
- bxn_l1a  out  12  header word 1, bits [11:0].
- l1a_cnt  out  12  header word 2, bits [11:0].
- rdout_cnt  out  12  header word 3, bits [11:0].
- lct_bins  out  4  bits [8:5] of header word 7.
- raw_bins  out  5  bits [4:0] of header word 7.
- good_frames  out  16  saturating count of good frames.
- bad_frames  out  16  saturating count of bad frames.

Behaviour:
- Reset: all outputs are 0 and the state machine goes to IDLE. Reset mid-frame discards the frame with no frame_done pulse.
- Frame words are indexed from 0 at the header.
  - w0 = 19'h0DB0A.
  - w1..w3 have bits [18:12] = 7'h0D.
  - w4..w6 have bits [18:15] = 0.
  - w7 has bits [14:9] = 6'h05.
  - Body words follow; padding words 19'h03000 may appear before the end marker.
  - End marker = 19'h0DE0D.
  - Then two CRC words, then the trailer.
  - CRC words: CRC lo is crc[10:0] and CRC hi is crc[21:11], each in bits [10:0] with bits [18:11] = 0.
  - Trailer: bits [18:11] = 8'h3A and bits [10:0] = total frame word count N, including header and trailer.
- States:
  - IDLE: idle words are ignored. On 19'h0DB0A go to HDR and set word counter wc=1. Any other bit-18=0 word sets hdr_err; emit frame_done (frame_ok=0) on the next cycle and stay in IDLE.
  - HDR: checks and captures w1..w7. A wrong marker sets hdr_err but parsing continues. After w7 go to BODY.
  - BODY: accepts any bit-18=0 word. On 19'h0DE0D go to CRC0.
  - CRC0: take CRC lo, go to CRC1.
  - CRC1: take CRC hi, go to TRL.
  - TRL: check the trailer, then go to DONE.
  - DONE: one cycle. Pulse frame_done, update the counters, return to IDLE. A new header word arriving in the DONE cycle is accepted, so back-to-back frames are supported.
- Length check: len_err is set if any of the following holds:
  - the trailer field differs from wc;
  - wc[1:0] is not 0;
  - wc exceeds MAX_WORDS;
  - the trailer marker is wrong.
- The word counter wc is 11 bits and saturates at 2047; it does not wrap.
- CRC-22: polynomial x^22+x+1, seed 0. Runs over bits [15:0] of every word from w0 through the end marker inclusive.
  - The expected CRC is compared against the received {hi, lo}; a mismatch sets crc_err.
- Abort: an idle word while in HDR..TRL, or 19'h0DB0A in BODY, sets abort. The frame ends in DONE.
  - If the aborting word was a header, the checker re-enters HDR with wc=1 in the same cycle after DONE; the header is stored in a 1-word hold register.
- Latency: frame_done is asserted 2 cycles after the trailer word is sampled (1 cycle input register + TRL→DONE).
- Field outputs hold their values until the next frame's w1..w7 overwrite them.
- Counters saturate at 16'hFFFF.

Optional Feature:
- Macro: DAQ_RX_TIMEOUT_EN.
- Compiled in: a 12-bit cycle counter runs from the header.
  - If it reaches TIMEOUT before TRL completes, the checker sets err[4] and goes to DONE.
  - Words are then ignored until an idle word.
- Compiled out: no counter, and err[4] is tied to 0.

Decomposition:
- Shared package daq_pkg holds:
  - word constants: DAQ_IDLE=19'h40000, DAQ_HDR=19'h0DB0A, DAQ_EOF=19'h0DE0D, DAQ_PAD=19'h03000, DAQ_TRL_TAG=8'h3A;
  - the state enum;
  - the error bit indices.
- Sub-module crc22_chk: clear, enable and 16-bit data inputs; 22-bit registered CRC output. The producing side can reuse it.

Test Plan:
- Good frame, N=16: lct_bins=0, raw_bins=0, header 0x0DB0A, w1=0x0D123, w2=0x0D045, w3=0x0D007, padding to 12 words, end marker, correct CRC, trailer 0x1D010 -> frame_done with frame_ok=1, err=0, bxn_l1a=0x123, l1a_cnt=0x045, rdout_cnt=0x007, good_frames=1.
- Same frame with one body bit flipped -> crc_err=1, err=5'b00100, bad_frames=1.
- Trailer field 0x00C on a 16-word frame -> len_err only. Separately, a 14-word frame -> len_err from the padding check.
- Idle word 0x40000 inserted at w9 -> abort=1 and frame_done 2 cycles later. A header at w9 instead -> abort, then the next frame parses with bxn_l1a taken from the new w1.
- Two back-to-back good frames with no idle between them -> two frame_done pulses, good_frames=2.
- With DAQ_RX_TIMEOUT_EN and TIMEOUT=20: a header followed by 30 body words -> err[4]=1 at cycle 20. Hard_rst pulsed mid-frame -> no frame_done, and all outputs are 0.
